relu_pool_pack: RTL and testbench

RELU_POOL_PACK -- requirements
Module: relu_pool_pack

---
 rtl/relu_pool_pack.sv | 112 +++++++++++
 tb/tb_relu_pool_pack.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/relu_pool_pack.sv
// Activation + max-pool + 4-lane packer feeding a 64-bit output buffer port.
// Optional ReLU activation is enabled by defining RELU_POOL_PACK_RELU_EN.
module relu_pool_pack #(
  parameter int DATA_W      = 16,
  parameter int POOL        = 2,
  parameter int PLANE_WORDS = 64,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_ena,
  output logic [7:0]        out_wea,
  output logic [ADDR_W-1:0] out_addr,
  output logic [63:0]       out_dina,
  output logic              plane_done,
  output logic              busy
);

  localparam int CNT_W = (POOL > 1) ? $clog2(POOL) : 1;

  logic [CNT_W-1:0]         r_pool_cnt;
  logic [1:0]               r_lane_cnt;
  logic signed [DATA_W-1:0] r_max;
  logic [DATA_W-1:0]        r_lanes [4];
  logic [ADDR_W-1:0]        r_next_addr;
  logic [ADDR_W-1:0]        r_out_addr;
  logic [63:0]              r_out_dina;
  logic                     r_out_ena;
  logic [7:0]               r_out_wea;
  logic                     r_plane_done;

  logic signed [DATA_W-1:0] w_act;
  logic signed [DATA_W-1:0] w_win_max;
  logic                     w_win_done;
  logic                     w_flush_win;
  logic                     w_place;
  logic [2:0]               w_fill;
  logic                     w_write;
  logic [DATA_W-1:0]        w_lanes [4];
  logic [4*DATA_W-1:0]      w_word;
  logic [7:0]               w_wea;

`ifdef RELU_POOL_PACK_RELU_EN
  assign w_act = in_data[DATA_W-1] ? '0 : $signed(in_data);
`else
  assign w_act = $signed(in_data);
`endif

  always_comb begin
    w_win_max = r_max;
    if (in_valid && ((r_pool_cnt == '0) || (w_act > r_max)))
      w_win_max = w_act;
    w_win_done  = in_valid && (r_pool_cnt == CNT_W'(POOL - 1));
    // A flush closes a window only if it holds samples and did not just complete.
    w_flush_win = flush && !w_win_done && (in_valid || (r_pool_cnt != '0));
    w_place     = w_win_done || w_flush_win;
    w_fill      = {1'b0, r_lane_cnt} + {2'b00, w_place};
    w_write     = (w_fill == 3'd4) || (flush && (w_fill != 3'd0));
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_lanes[gi] = (w_place && (r_lane_cnt == 2'(gi))) ? w_win_max : r_lanes[gi];
    assign w_word[4*DATA_W-1-DATA_W*gi -: DATA_W] = w_lanes[gi];
    assign w_wea[7-2*gi -: 2] = (w_fill > 3'(gi)) ? 2'b11 : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pool_cnt   <= '0;
      r_lane_cnt   <= '0;
      r_max        <= '0;
      r_next_addr  <= '0;
      r_out_addr   <= '0;
      r_out_dina   <= '0;
      r_out_ena    <= 1'b0;
      r_out_wea    <= '0;
      r_plane_done <= 1'b0;
      for (int i = 0; i < 4; i++) r_lanes[i] <= '0;
    end else begin
      r_out_ena    <= w_write;
      r_out_wea    <= w_write ? w_wea : 8'h00;
      r_plane_done <= w_write && (r_next_addr == ADDR_W'(PLANE_WORDS - 1));
      if (in_valid) r_max <= w_win_max;
      if (w_place || flush)
        r_pool_cnt <= '0;
      else if (in_valid)
        r_pool_cnt <= r_pool_cnt + CNT_W'(1);
      // Lanes clear on write so unfilled lanes of a flushed word read as zero.
      if (w_write) begin
        r_out_dina  <= 64'(w_word);
        r_out_addr  <= r_next_addr;
        r_next_addr <= (r_next_addr == ADDR_W'(PLANE_WORDS - 1)) ? '0 : r_next_addr + ADDR_W'(1);
        r_lane_cnt  <= '0;
        for (int i = 0; i < 4; i++) r_lanes[i] <= '0;
      end else begin
        r_lane_cnt <= w_fill[1:0];
        for (int i = 0; i < 4; i++) r_lanes[i] <= w_lanes[i];
      end
    end
  end

  assign out_ena    = r_out_ena;
  assign out_wea    = r_out_wea;
  assign out_addr   = r_out_addr;
  assign out_dina   = r_out_dina;
  assign plane_done = r_plane_done;
  assign busy       = (r_pool_cnt != '0) || (r_lane_cnt != '0);

endmodule

// File: tb/tb_relu_pool_pack.sv
// Self-checking bench for relu_pool_pack: directed cases plus random traffic
// compared against a queue-based window/lane model.
module tb_relu_pool_pack;

  localparam int DATA_W = 16;
  localparam int POOL   = 2;
  localparam int PW     = 4;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              flush = 1'b0;
  logic              out_ena;
  logic [7:0]        out_wea;
  logic [ADDR_W-1:0] out_addr;
  logic [63:0]       out_dina;
  logic              plane_done;
  logic              busy;

  relu_pool_pack #(.DATA_W(DATA_W), .POOL(POOL), .PLANE_WORDS(PW), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .out_ena(out_ena), .out_wea(out_wea), .out_addr(out_addr), .out_dina(out_dina),
    .plane_done(plane_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          win[$];
  int          lanes[$];
  int          next_addr = 0;
  logic [63:0] m_dina = '0;
  logic [15:0] m_addr = '0;
  logic        m_ena = 1'b0;
  logic [7:0]  m_wea = '0;
  logic        m_pd = 1'b0;

  function automatic int act(logic [15:0] d);
    int v;
    v = int'($signed(d));
`ifdef RELU_POOL_PACK_RELU_EN
    if (v < 0) v = 0;
`endif
    return v;
  endfunction

  function automatic int qmax(int q[$]);
    int m;
    m = q[0];
    foreach (q[i]) if (q[i] > m) m = q[i];
    return m;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(bit r, bit v, logic [15:0] d, bit f);
    logic [63:0] w;
    m_ena = 1'b0; m_wea = '0; m_pd = 1'b0;
    if (r) begin
      win.delete(); lanes.delete();
      next_addr = 0; m_addr = '0; m_dina = '0;
      return;
    end
    if (v) begin
      win.push_back(act(d));
      if (win.size() == POOL) begin
        lanes.push_back(qmax(win));
        win.delete();
      end
    end
    if (f && win.size() > 0) begin
      lanes.push_back(qmax(win));
      win.delete();
    end
    if (lanes.size() == 4 || (f && lanes.size() > 0)) begin
      w = '0;
      foreach (lanes[i]) begin
        w[63-16*i -: 16] = 16'(lanes[i]);
        m_wea[7-2*i -: 2] = 2'b11;
      end
      m_ena  = 1'b1;
      m_dina = w;
      m_addr = 16'(next_addr);
      m_pd   = (next_addr == PW - 1);
      next_addr = (next_addr + 1) % PW;
      lanes.delete();
    end
  endtask

  task automatic step(bit r, bit v, logic [15:0] d, bit f);
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; flush = f;
    @(posedge clk);
    #1;
    model(r, v, d, f);
    check("out_ena", 64'(out_ena), 64'(m_ena));
    check("out_wea", 64'(out_wea), 64'(m_wea));
    check("plane_done", 64'(plane_done), 64'(m_pd));
    check("out_addr", 64'(out_addr), 64'(m_addr));
    check("out_dina", out_dina, m_dina);
    check("busy", 64'(busy), 64'(win.size() > 0 || lanes.size() > 0));
  endtask

  initial begin
    int samp35[8];
    samp35 = '{5, 9, 3, 2, 7, 7, 1, 8};

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Basic packing: expect 0009_0003_0007_0008 at addr 0
    foreach (samp35[i]) step(0, 1, 16'(samp35[i]), 0);
    check("req035_dina", out_dina, 64'h0009_0003_0007_0008);
    check("req035_ena", 64'(out_ena), 64'd1);
    step(0, 0, 0, 0);

    // Negative pairs
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 16'hFFFC, 0);
      step(0, 1, 16'hFFFE, 0);
    end
`ifdef RELU_POOL_PACK_RELU_EN
    check("req036_dina", out_dina, 64'h0000_0000_0000_0000);
`else
    check("req036_dina", out_dina, 64'hFFFE_FFFE_FFFE_FFFE);
`endif
    step(0, 0, 0, 0);

    // Partial word via flush, then idle flush
    step(0, 1, 16'd10, 0);
    step(0, 1, 16'd20, 0);
    step(0, 1, 16'd30, 0);
    step(0, 0, 0, 1);
    check("req038_dina", out_dina, 64'h0014_001E_0000_0000);
    check("req038_wea", 64'(out_wea), 64'hF0);
    step(0, 0, 0, 1);
    check("req038_idle", 64'(out_ena), 64'd0);

    // Flush concurrent with the second sample
    step(0, 1, 16'd1, 0);
    step(0, 1, 16'd2, 1);
    check("req040_dina", out_dina, 64'h0002_0000_0000_0000);
    check("req040_wea", 64'(out_wea), 64'hC0);

    // Plane wrap: 5 full words from reset
    step(1, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(0, 1, 16'($urandom), 0);
    check("req037_wrap_addr", 64'(out_addr), 64'd0);

    // Reset in the cycle lane 3 fills
    for (int i = 0; i < 7; i++) step(0, 1, 16'($urandom), 0);
    step(1, 1, 16'd77, 0);
    step(0, 0, 0, 0);
    check("req039_ena", 64'(out_ena), 64'd0);
    check("req039_busy", 64'(busy), 64'd0);
    check("req039_addr", 64'(out_addr), 64'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 80),
           16'($urandom), ($urandom_range(0, 99) < 6));
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
